// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster-order feature-map stream.
// Even rows park pairwise maxima in a line buffer; odd rows finish each window and emit it.
module max_pool_2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int FMAP_COLS  = 8,
    parameter int FMAP_ROWS  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int CW       = (FMAP_COLS > 1) ? $clog2(FMAP_COLS) : 1;
    localparam int RW       = (FMAP_ROWS > 1) ? $clog2(FMAP_ROWS) : 1;
    localparam int LB_DEPTH = FMAP_COLS / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(FMAP_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_ROWS - 1);

    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic signed [DATA_WIDTH-1:0] hold;
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] lb_rd;
    logic signed [DATA_WIDTH-1:0] pool_max;
    logic signed [DATA_WIDTH-1:0] line_buf [LB_DEPTH];
    logic [LB_AW-1:0]             lb_idx;
    logic                         accept;
    logic                         col_end;
    logic                         row_end;

    assign sample  = in_data;
    assign accept  = in_valid && !flush;
    assign col_end = (col == COL_LAST);
    assign row_end = (row == ROW_LAST);
    assign lb_idx  = LB_AW'(col >> 1);

    always_comb begin
        pair_max = (sample > hold) ? sample : hold;
        lb_rd    = line_buf[lb_idx];
        pool_max = (lb_rd > pair_max) ? lb_rd : pair_max;
    end

    // Line buffer carries no reset: every entry is rewritten on an even row before an odd row reads it.
    always_ff @(posedge clock) begin
        if (accept && col[0] && !row[0]) begin
            line_buf[lb_idx] <= pair_max;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (flush) begin
                col <= '0;
                row <= '0;
            end else if (in_valid) begin
                if (!col[0]) begin
                    hold <= sample;
                end else if (row[0]) begin
                    out_data  <= pool_max;
                    out_valid <= 1'b1;
                    out_last  <= row_end && col_end;
                end

                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width in bits, two's-complement signed; matches the network data width.
REQ-002 Parameter FMAP_COLS, default 8: feature-map columns; SHALL be even and >= 2.
REQ-003 Parameter FMAP_ROWS, default 8: feature-map rows; SHALL be even and >= 2.
REQ-004 clock  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous frame restart; discards partial-frame state.
REQ-007 in_valid  input  1  in_data carries a valid sample this cycle; no backpressure, so every valid sample is accepted.
REQ-008 in_data  input  DATA_WIDTH  rectified activation sample, raster order (row-major, column 0 first).
REQ-009 out_valid  output  1  registered; single-cycle pulse per pooled result.
REQ-010 out_data  output  DATA_WIDTH  registered pooled maximum.
REQ-011 out_last  output  1  registered; high with out_valid on the final pooled result of a frame.

Function
REQ-012 The block SHALL keep a column counter (0..FMAP_COLS-1) and a row counter (0..FMAP_ROWS-1), advancing only on accepted samples (in_valid=1, flush=0).
REQ-013 Column wrap: col FMAP_COLS-1 -> 0 with row+1; row FMAP_ROWS-1, col FMAP_COLS-1 -> row 0, col 0 (next frame, no idle cycle required).
REQ-014 Even column: hold register SHALL capture in_data.
REQ-015 Odd column: pair_max = signed max(hold, in_data).
REQ-016 Even row, odd column: pair_max SHALL be written to line-buffer entry col/2 (FMAP_COLS/2 entries x DATA_WIDTH).
REQ-017 Odd row, odd column: out_data SHALL load signed max(line_buffer[col/2], pair_max), with out_valid=1 on the following cycle (latency 1 clock from the accepting edge).
REQ-018 out_last SHALL be 1 exactly when the emitted result comes from row FMAP_ROWS-1, col FMAP_COLS-1; 0 otherwise.
REQ-019 out_valid and out_last SHALL be 0 in every cycle not described by REQ-017/018; out_data holds its last value when out_valid=0.
REQ-020 Comparisons SHALL be signed; equal operands yield that value; no saturation or width change (output width = input width).
REQ-021 Gaps in in_valid of any length SHALL NOT alter results; state held while in_valid=0.
REQ-022 flush=1 SHALL, at the next edge, zero both counters and force out_valid=0 and out_last=0; a sample presented with flush=1 is discarded; the next accepted sample is (row 0, col 0).
REQ-023 flush has priority over in_valid; line-buffer and hold contents need not be cleared (overwritten before use).
REQ-024 Exactly FMAP_COLS*FMAP_ROWS/4 results SHALL be produced per complete frame, in raster order of the pooled map.

Reset
REQ-025 reset=0 SHALL asynchronously force: counters=0, out_valid=0, out_last=0, out_data=0, hold=0.
REQ-026 Line-buffer contents are not reset.
REQ-027 Reset asserted mid-frame discards the partial frame; after release the first accepted sample is (row 0, col 0).
REQ-028 No output pulse SHALL occur in the first cycle after reset release.

Verification
REQ-029 FMAP 4x4, in_data 0..15 raster, in_valid continuous -> out_data 5,7,13,15; out_valid one cycle after samples 5(idx),7,13,15; out_last only with 15.
REQ-030 FMAP 4x4, values -16..-1 raster -> out_data -11,-9,-3,-1 (signed compare), out_last with -1.
REQ-031 Same stimulus as REQ-029 with random 0-3 cycle in_valid gaps -> identical output sequence, each out_valid one cycle after its completing sample.
REQ-032 Flush after 6 samples of a 4x4 frame, then full ramp 0..15 -> no output from partial frame; outputs 5,7,13,15; a sample presented with flush ignored.
REQ-033 Reset pulsed after 10 samples, then full ramp 100..115 -> outputs 105,107,113,115, out_last on 115; all outputs 0 during reset.
REQ-034 Two back-to-back 4x4 frames (0..15 then 15..0) with no idle cycle -> 5,7,13,15 then 15,13,7,5 (maxima of {15,14,11,10}=15, {13,12,9,8}=13, {7,6,3,2}=7, {5,4,1,0}=5); out_last on both 4th results.
